// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: passes big-endian message words through, appends the
// 0x80 marker, zero fill and 64-bit bit length, and emits 33-bit half-swap-encoded words.
module sha256_msg_padder #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic [2:0]        in_nbytes_i,
    input  logic              order_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W:0]   out_data_o,
    output logic              out_block_last_o,
    output logic              out_msg_last_o,
    output logic              busy_o
);

    localparam int unsigned HALF_W = WORD_W / 2;
    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0]  IDX_PRE_LEN   = CNT_W'(13);
    localparam logic [CNT_W-1:0]  IDX_BLOCK_END = CNT_W'(15);
    localparam logic [WORD_W-1:0] MARK_WORD     = WORD_W'(128) << (WORD_W - 8);
    localparam logic [2:0]        FULL_BYTES    = 3'(NBYTES);

    typedef enum logic [2:0] {
        S_DATA,
        S_MARK,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    wcnt_q;
    logic [LEN_W-1:0]    bitlen_q;

    logic                load_en;
    logic                accept;
    logic                word_load;
    logic                msg_last_c;
    logic [WORD_W-1:0]   word_c;
    logic [WORD_W-1:0]   pad_word;
    logic [2:0]          nbytes_sat;
    logic [LEN_W-1:0]    len_inc;

    // Final partial word: keep valid bytes, marker right after them, zero the rest.
    always_comb begin
        nbytes_sat = (in_nbytes_i > FULL_BYTES) ? FULL_BYTES : in_nbytes_i;
        pad_word   = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (b < 32'(nbytes_sat)) begin
                pad_word[WORD_W-1-8*b -: 8] = in_data_i[WORD_W-1-8*b -: 8];
            end else if (b == 32'(nbytes_sat)) begin
                pad_word[WORD_W-1-8*b -: 8] = 8'h80;
            end
        end
        len_inc = in_last_i ? LEN_W'({nbytes_sat, 3'b000}) : LEN_W'(WORD_W);
    end

    // Next-state and word selection; every transition is tied to an output load.
    always_comb begin
        load_en    = !out_valid_o || out_ready_i;
        in_ready_o = (state_q == S_DATA) && load_en;
        accept     = in_valid_i && in_ready_o;
        state_d    = state_q;
        word_load  = 1'b0;
        word_c     = '0;
        msg_last_c = 1'b0;

        case (state_q)
            S_DATA: begin
                if (accept) begin
                    word_load = 1'b1;
                    if (!in_last_i) begin
                        word_c = in_data_i;
                    end else if (nbytes_sat == FULL_BYTES) begin
                        word_c  = in_data_i;
                        state_d = S_MARK;
                    end else begin
                        word_c  = pad_word;
                        state_d = (wcnt_q == IDX_PRE_LEN) ? S_LEN_HI : S_ZERO;
                    end
                end
            end
            S_MARK: begin
                if (load_en) begin
                    word_load = 1'b1;
                    word_c    = MARK_WORD;
                    state_d   = (wcnt_q == IDX_PRE_LEN) ? S_LEN_HI : S_ZERO;
                end
            end
            S_ZERO: begin
                if (load_en) begin
                    word_load = 1'b1;
                    if (wcnt_q == IDX_PRE_LEN) begin
                        state_d = S_LEN_HI;
                    end
                end
            end
            S_LEN_HI: begin
                if (load_en) begin
                    word_load = 1'b1;
                    word_c    = bitlen_q[LEN_W-1 -: WORD_W];
                    state_d   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (load_en) begin
                    word_load  = 1'b1;
                    word_c     = bitlen_q[WORD_W-1:0];
                    msg_last_c = 1'b1;
                    state_d    = S_DATA;
                end
            end
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register, word index and bit-length accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o      <= 1'b0;
            out_data_o       <= '0;
            out_block_last_o <= 1'b0;
            out_msg_last_o   <= 1'b0;
            wcnt_q           <= '0;
            bitlen_q         <= '0;
            busy_o           <= 1'b0;
        end else begin
            if (word_load) begin
                out_valid_o      <= 1'b1;
                out_data_o       <= order_i ? {1'b1, word_c[HALF_W-1:0], word_c[WORD_W-1:HALF_W]}
                                            : {1'b0, word_c};
                out_block_last_o <= (wcnt_q == IDX_BLOCK_END);
                out_msg_last_o   <= msg_last_c;
                wcnt_q           <= wcnt_q + CNT_W'(1);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (word_load && msg_last_c) begin
                bitlen_q <= '0;
            end else if (accept) begin
                bitlen_q <= bitlen_q + len_inc;
            end

            if (accept) begin
                busy_o <= 1'b1;
            end else if (out_valid_o && out_ready_i && out_msg_last_o) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level FIPS 180-4 padding model, per-transfer
// compare process, directed messages with literal pins, backpressure and reset cases.
module tb_sha256_msg_padder;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        in_last_i;
    logic [2:0]  in_nbytes_i;
    logic        order_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [32:0] out_data_o;
    logic        out_block_last_o;
    logic        out_msg_last_o;
    logic        busy_o;

    sha256_msg_padder dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .in_last_i        (in_last_i),
        .in_nbytes_i      (in_nbytes_i),
        .order_i          (order_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_block_last_o (out_block_last_o),
        .out_msg_last_o   (out_msg_last_o),
        .busy_o           (busy_o)
    );

    typedef struct packed {
        logic [32:0] data;
        logic        blast;
        logic        mlast;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] got_q[$];
    logic [7:0]  msg_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;
    bit          stall    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: pad the byte string per FIPS 180-4, then slice into encoded words.
    task automatic model_push(input bit ord_first, input bit ord_rest);
        logic [7:0]  p[$];
        logic [63:0] len;
        logic [31:0] w;
        int          nw;
        bit          o;
        exp_t        e;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        len = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            w = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            o = (i == 0) ? ord_first : ord_rest;
            e.data  = o ? {1'b1, w[15:0], w[31:16]} : {1'b0, w};
            e.blast = ((i % 16) == 15);
            e.mlast = (i == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every word that transfers must match the model's next word.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (out_valid_o && !out_ready_i) check("in_ready_while_held", 64'(in_ready_o), 64'd0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data_o), 64'h1_dead_dead);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data_o), 64'(e.data));
                    check("block_last", 64'(out_block_last_o), 64'(e.blast));
                    check("msg_last", 64'(out_msg_last_o), 64'(e.mlast));
                end
                got_q.push_back(out_data_o);
            end
        end
    end

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic make_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'(i * 7 + 3));
    endtask

    task automatic make_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    // Drives msg_q as words; called just after a rising edge.
    task automatic send_msg(input bit ord_first, input bit ord_rest);
        int          len;
        int          nw;
        int          guard;
        int          idx;
        logic [31:0] d;
        len = msg_q.size();
        nw  = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = 32'h0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * w + k;
                d   = {d[23:0], (idx < len) ? msg_q[idx] : 8'h00};
            end
            if (len == 0) d = 32'hdead_beef;
            in_valid_i  = 1'b1;
            in_data_i   = d;
            in_last_i   = (w == nw - 1);
            in_nbytes_i = (w == nw - 1) ? 3'(len - 4 * (nw - 1)) : 3'd4;
            order_i     = (w == 0) ? ord_first : ord_rest;
            guard = 0;
            forever begin
                @(negedge clk);
                if (in_ready_o) break;
                guard++;
                if (guard > 1000) break;
            end
            if (guard > 1000) begin
                check("input_accept_timeout", 64'(guard), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
            if (w == 0) begin
                check("first_word_latency", 64'(out_valid_o), 64'd1);
                check("busy_after_first", 64'(busy_o), 64'd1);
            end
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        order_i    = ord_rest;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("busy_idle", 64'(busy_o), 64'd0);
        check("valid_idle", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
        check({tag, "_out_data"}, 64'(out_data_o), 64'd0);
        check({tag, "_block_last"}, 64'(out_block_last_o), 64'd0);
        check({tag, "_msg_last"}, 64'(out_msg_last_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int lens[5] = '{52, 55, 60, 63, 64};
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = 32'h0;
        in_last_i   = 1'b0;
        in_nbytes_i = 3'd0;
        order_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;

        // "abc"
        make_abc();
        model_push(1'b0, 1'b0);
        check("model_abc_count", 64'(exp_q.size()), 64'd16);
        check("model_abc_w0", 64'(exp_q[0].data), 64'h0_6162_6380);
        check("model_abc_w15", 64'(exp_q[15].data), 64'h0_0000_0018);
        got_q.delete();
        send_msg(1'b0, 1'b0);
        wait_done();
        check("abc_count", 64'(got_q.size()), 64'd16);
        check("abc_w0", 64'(got_q[0]), 64'h0_6162_6380);
        check("abc_w14", 64'(got_q[14]), 64'h0);
        check("abc_w15", 64'(got_q[15]), 64'h0_0000_0018);

        // Empty message
        make_msg(0);
        model_push(1'b0, 1'b0);
        check("model_empty_w0", 64'(exp_q[0].data), 64'h0_8000_0000);
        got_q.delete();
        send_msg(1'b0, 1'b0);
        wait_done();
        check("empty_count", 64'(got_q.size()), 64'd16);
        check("empty_w0", 64'(got_q[0]), 64'h0_8000_0000);
        check("empty_w15", 64'(got_q[15]), 64'h0);

        // 56-byte message: marker at index 14, spills into a second block
        make_msg(56);
        model_push(1'b0, 1'b0);
        check("model_56_count", 64'(exp_q.size()), 64'd32);
        check("model_56_w31", 64'(exp_q[31].data), 64'h0_0000_01c0);
        got_q.delete();
        send_msg(1'b0, 1'b0);
        wait_done();
        check("m56_count", 64'(got_q.size()), 64'd32);
        check("m56_w14", 64'(got_q[14]), 64'h0_8000_0000);
        check("m56_w15", 64'(got_q[15]), 64'h0);
        check("m56_w30", 64'(got_q[30]), 64'h0);
        check("m56_w31", 64'(got_q[31]), 64'h0_0000_01c0);

        // Half-swap encoding on the first word only
        make_abc();
        model_push(1'b1, 1'b0);
        check("model_swap_w0", 64'(exp_q[0].data), 64'h1_6380_6162);
        got_q.delete();
        send_msg(1'b1, 1'b0);
        wait_done();
        check("swap_w0", 64'(got_q[0]), 64'h1_6380_6162);
        check("swap_w15", 64'(got_q[15]), 64'h0_0000_0018);

        // Placement boundaries around indices 13..15
        foreach (lens[i]) begin
            make_msg(lens[i]);
            model_push(1'(i % 2), 1'(i % 2));
            send_msg(1'(i % 2), 1'(i % 2));
            wait_done();
        end

        // 3-block message, free-flowing then with random backpressure
        make_msg(150);
        model_push(1'b1, 1'b1);
        check("model_150_count", 64'(exp_q.size()), 64'd48);
        send_msg(1'b1, 1'b1);
        wait_done();
        stall = 1;
        model_push(1'b0, 1'b0);
        send_msg(1'b0, 1'b0);
        wait_done();
        stall = 0;
        @(posedge clk);
        #1;

        // Reset while emitting zero fill
        make_abc();
        model_push(1'b0, 1'b0);
        send_msg(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        mon_en = 1;
        @(posedge clk);
        #1;
        make_abc();
        model_push(1'b0, 1'b0);
        send_msg(1'b0, 1'b0);
        wait_done();
        check("post_reset_count", 64'(got_q.size()), 64'd16);
        check("post_reset_w0", 64'(got_q[0]), 64'h0_6162_6380);
        check("post_reset_len", 64'(got_q[15]), 64'h0_0000_0018);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
